// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, flag bit positions
// and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_ADDC = 4'd1;
  localparam logic [3:0] ALU_OP_SUB  = 4'd2;
  localparam logic [3:0] ALU_OP_SUBC = 4'd3;
  localparam logic [3:0] ALU_OP_NOR  = 4'd4;
  localparam logic [3:0] ALU_OP_NAND = 4'd5;
  localparam logic [3:0] ALU_OP_XOR  = 4'd6;
  localparam logic [3:0] ALU_OP_XNOR = 4'd7;
  localparam logic [3:0] ALU_OP_LOAD = 4'd8;
  localparam logic [3:0] ALU_OP_SHL  = 4'd9;
  localparam logic [3:0] ALU_OP_SHR  = 4'd10;
  localparam logic [3:0] ALU_OP_ASR  = 4'd11;
  localparam logic [3:0] ALU_OP_ROL  = 4'd12;
  localparam logic [3:0] ALU_OP_ROR  = 4'd13;
  localparam logic [3:0] ALU_OP_MUL  = 4'd14;
  localparam logic [3:0] ALU_OP_NOP  = 4'd15;

  // Flags = {NEG, ZERO, OV, CARRY}
  localparam int FL_CARRY = 0;
  localparam int FL_OV    = 1;
  localparam int FL_ZERO  = 2;
  localparam int FL_NEG   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  // Shift/rotate opcodes occupy one contiguous range.
  function automatic logic is_shift(input logic [3:0] op);
    return (op >= ALU_OP_SHL) && (op <= ALU_OP_ROR);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per step.
// 'product' is the value the product register takes after the pending step,
// so the owner can capture the final result on the same edge as the last step.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0]     psum;

  // Add multiplicand into the upper half when the current multiplier lsb is set,
  // then shift the whole register right one place.
  always_comb begin
    psum    = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{p[0]}}};
    product = {psum, p[WIDTH-1:1]};
  end

  assign last = (cnt == CW'(WIDTH - 1));

  // Product register and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mcand <= '0;
      p     <= '0;
    end else if (load) begin
      cnt   <= '0;
      mcand <= multiplicand;
      p     <= {{WIDTH{1'b0}}, multiplier};
    end else if (step) begin
      cnt   <= cnt + 1'b1;
      p     <= product;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake. Single-cycle ops complete
// on the accept edge; shifts take n edges; MUL takes WIDTH edges. AR/HR/Flags
// are only written on the completing edge.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)  // derived, not meant to be overridden
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             oper2_sel,
  input  logic [WIDTH-1:0] IBR,
  input  logic [WIDTH-1:0] MBR,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] AR,
  output logic [WIDTH-1:0] HR,
  output logic [3:0]       Flags
);

  localparam int MSB = WIDTH - 1;

  state_t             state, state_n;
  logic [WIDTH-1:0]   oper2;
  logic [WIDTH-1:0]   ar_n, hr_n;
  logic [3:0]         fl_n;
  logic               done_n;
  logic [WIDTH-1:0]   work, work_n;
  logic [SHW-1:0]     cnt, cnt_n;
  logic [3:0]         sop, sop_n;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic               mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] product;

  assign oper2 = oper2_sel ? MBR : IBR;
  assign busy  = (state != ST_IDLE);

  // One-bit shift/rotate; returns {bit shifted out, new value}.
  function automatic logic [WIDTH:0] shift1(input logic [3:0] o, input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    r = {v[0], 1'b0, v[WIDTH-1:1]};
    case (o)
      ALU_OP_SHL: r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      ALU_OP_ASR: r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      ALU_OP_ROL: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      ALU_OP_ROR: r = {v[0], v[0], v[WIDTH-1:1]};
      default: ;
    endcase
    return r;
  endfunction

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (arst),
    .load         (mul_load),
    .step         (mul_step),
    .multiplicand (AR),
    .multiplier   (oper2),
    .product      (product),
    .last         (mul_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (arst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next state, next architectural values and sub-unit controls.
  always_comb begin
    state_n  = state;
    ar_n     = AR;
    hr_n     = HR;
    fl_n     = Flags;
    done_n   = 1'b0;
    work_n   = work;
    cnt_n    = cnt;
    sop_n    = sop;
    mul_load = 1'b0;
    mul_step = 1'b0;
    sum      = '0;
    sh       = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          done_n = 1'b1;
          case (op)
            ALU_OP_ADD, ALU_OP_ADDC: begin
              sum = {1'b0, AR} + {1'b0, oper2}
                  + {{WIDTH{1'b0}}, (op == ALU_OP_ADDC) & Flags[FL_CARRY]};
              ar_n           = sum[WIDTH-1:0];
              fl_n[FL_CARRY] = sum[WIDTH];
              fl_n[FL_OV]    = (AR[MSB] == oper2[MSB]) & (sum[MSB] != AR[MSB]);
            end
            ALU_OP_SUB, ALU_OP_SUBC: begin
              // bit WIDTH of the difference is the borrow
              sum = {1'b0, AR} - {1'b0, oper2}
                  - {{WIDTH{1'b0}}, (op == ALU_OP_SUBC) & Flags[FL_CARRY]};
              ar_n           = sum[WIDTH-1:0];
              fl_n[FL_CARRY] = sum[WIDTH];
              fl_n[FL_OV]    = (AR[MSB] != oper2[MSB]) & (sum[MSB] != AR[MSB]);
            end
            ALU_OP_NOR:  ar_n = ~(AR | oper2);
            ALU_OP_NAND: ar_n = ~(AR & oper2);
            ALU_OP_XOR:  ar_n = AR ^ oper2;
            ALU_OP_XNOR: ar_n = ~(AR ^ oper2);
            ALU_OP_LOAD: ar_n = oper2;
            ALU_OP_MUL: begin
              done_n   = 1'b0;
              state_n  = ST_MUL;
              mul_load = 1'b1;
            end
            default: begin
              // zero shift amount degenerates into a single-cycle op
              if (is_shift(op) && (oper2[SHW-1:0] != '0)) begin
                done_n  = 1'b0;
                state_n = ST_SHIFT;
                work_n  = AR;
                cnt_n   = oper2[SHW-1:0];
                sop_n   = op;
              end
            end
          endcase
          // Z/N track AR for every completed op except NOP
          if (done_n && (op != ALU_OP_NOP)) begin
            fl_n[FL_ZERO] = (ar_n == '0);
            fl_n[FL_NEG]  = ar_n[MSB];
          end
        end
      end
      ST_SHIFT: begin
        sh     = shift1(sop, work);
        work_n = sh[WIDTH-1:0];
        cnt_n  = cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          ar_n           = sh[WIDTH-1:0];
          fl_n[FL_CARRY] = sh[WIDTH];
          fl_n[FL_ZERO]  = (sh[WIDTH-1:0] == '0);
          fl_n[FL_NEG]   = sh[MSB];
          done_n         = 1'b1;
          state_n        = ST_IDLE;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          {hr_n, ar_n}   = product;
          fl_n[FL_CARRY] = |product[2*WIDTH-1:WIDTH];
          fl_n[FL_OV]    = 1'b0;
          fl_n[FL_ZERO]  = (product == '0);
          fl_n[FL_NEG]   = product[2*WIDTH-1];
          done_n         = 1'b1;
          state_n        = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Architectural and work registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      AR    <= '0;
      HR    <= '0;
      Flags <= '0;
      done  <= 1'b0;
      work  <= '0;
      cnt   <= '0;
      sop   <= ALU_OP_NOP;
    end else begin
      AR    <= ar_n;
      HR    <= hr_n;
      Flags <= fl_n;
      done  <= done_n;
      work  <= work_n;
      cnt   <= cnt_n;
      sop   <= sop_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: table of sequential ops with
// hand-computed results, plus hand sequences for busy-time start pulses,
// back-to-back accept and reset mid-multiply.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       arst, start, oper2_sel;
  logic [3:0] op;
  logic [7:0] IBR, MBR;
  logic       busy, done;
  logic [7:0] AR, HR;
  logic [3:0] Flags;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .arst(arst), .start(start), .op(op), .oper2_sel(oper2_sel),
    .IBR(IBR), .MBR(MBR), .busy(busy), .done(done), .AR(AR), .HR(HR), .Flags(Flags)
  );

  typedef struct {
    logic [3:0] op;
    logic       sel;
    logic [7:0] ibr;
    logic [7:0] mbr;
    logic [7:0] ar;
    logic [7:0] hr;
    logic [3:0] fl;     // {N,Z,V,C}
    int         edges;  // edges after accept until completion
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] o, input logic s, input logic [7:0] i,
                              input logic [7:0] m, input logic [7:0] ar, input logic [7:0] hr,
                              input logic [3:0] fl, input int e);
    vec_t v;
    v.op = o; v.sel = s; v.ibr = i; v.mbr = m;
    v.ar = ar; v.hr = hr; v.fl = fl; v.edges = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one op and wait (bounded) for done; returns edge count or -1.
  task automatic run_op(input logic [3:0] o, input logic s, input logic [7:0] i,
                        input logic [7:0] m, output int edges, output logic busy0);
    @(negedge clk);
    op = o; oper2_sel = s; IBR = i; MBR = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = -1;
    busy0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   edges;
    logic busy0;

    //  op            sel ibr    mbr    AR     HR     NZVC  edges
    add(ALU_OP_LOAD, 0, 8'h7F, 8'h00, 8'h7F, 8'h00, 4'h0, 0);
    add(ALU_OP_ADD,  0, 8'h01, 8'h00, 8'h80, 8'h00, 4'hA, 0);
    add(ALU_OP_LOAD, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h6, 0);
    add(ALU_OP_SUB,  0, 8'h01, 8'h00, 8'hFF, 8'h00, 4'h9, 0);
    add(ALU_OP_SUBC, 0, 8'h00, 8'h00, 8'hFE, 8'h00, 4'h8, 0);
    add(ALU_OP_LOAD, 1, 8'h00, 8'h81, 8'h81, 8'h00, 4'h8, 0);
    add(ALU_OP_SHL,  0, 8'h03, 8'h00, 8'h08, 8'h00, 4'h0, 3);
    add(ALU_OP_LOAD, 0, 8'h80, 8'h00, 8'h80, 8'h00, 4'h8, 0);
    add(ALU_OP_ASR,  0, 8'h07, 8'h00, 8'hFF, 8'h00, 4'h8, 7);
    add(ALU_OP_SHR,  0, 8'h01, 8'h00, 8'h7F, 8'h00, 4'h1, 1);
    add(ALU_OP_SHL,  0, 8'h08, 8'h00, 8'h7F, 8'h00, 4'h1, 0);
    add(ALU_OP_ROL,  0, 8'h01, 8'h00, 8'hFE, 8'h00, 4'h8, 1);
    add(ALU_OP_ROR,  0, 8'h02, 8'h00, 8'hBF, 8'h00, 4'h9, 2);
    add(ALU_OP_LOAD, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 4'h9, 0);
    add(ALU_OP_MUL,  1, 8'h00, 8'hFF, 8'h01, 8'hFE, 4'h9, 8);
    add(ALU_OP_XOR,  0, 8'h01, 8'h00, 8'h00, 8'hFE, 4'h5, 0);
    add(ALU_OP_NOR,  0, 8'h00, 8'h00, 8'hFF, 8'hFE, 4'h9, 0);
    add(ALU_OP_NAND, 0, 8'hFF, 8'h00, 8'h00, 8'hFE, 4'h5, 0);
    add(ALU_OP_XNOR, 0, 8'h0F, 8'h00, 8'hF0, 8'hFE, 4'h9, 0);
    add(ALU_OP_NOP,  0, 8'h55, 8'h00, 8'hF0, 8'hFE, 4'h9, 0);
    add(ALU_OP_ADDC, 0, 8'h0F, 8'h00, 8'h00, 8'hFE, 4'h5, 0);
    add(ALU_OP_MUL,  0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h4, 8);
    add(ALU_OP_LOAD, 0, 8'h03, 8'h00, 8'h03, 8'h00, 4'h0, 0);
    add(ALU_OP_MUL,  0, 8'h05, 8'h00, 8'h0F, 8'h00, 4'h0, 8);
    add(ALU_OP_ADD,  0, 8'hF2, 8'h00, 8'h01, 8'h00, 4'h1, 0);
    add(ALU_OP_LOAD, 0, 8'h80, 8'h00, 8'h80, 8'h00, 4'h9, 0);
    add(ALU_OP_SUB,  0, 8'h01, 8'h00, 8'h7F, 8'h00, 4'h2, 0);
    add(ALU_OP_LOAD, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 4'hA, 0);

    // reset state
    arst = 1'b1; start = 1'b0; op = ALU_OP_NOP; oper2_sel = 1'b0; IBR = '0; MBR = '0;
    repeat (3) @(negedge clk);
    chk("reset AR", AR, 8'h00);
    chk("reset HR", HR, 8'h00);
    chk("reset Flags", Flags, 4'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    arst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].sel, vecs[i].ibr, vecs[i].mbr, edges, busy0);
      chk($sformatf("v%0d latency", i), edges, vecs[i].edges);
      chk($sformatf("v%0d busy", i), busy0, (vecs[i].edges > 0));
      chk($sformatf("v%0d HR_AR_Flags", i), {HR, AR, Flags}, {vecs[i].hr, vecs[i].ar, vecs[i].fl});
      @(negedge clk);
      chk($sformatf("v%0d done pulse", i), done, 1'b0);
    end

    // MUL with stray start pulses while busy, then back-to-back accept in done cycle
    @(negedge clk);
    op = ALU_OP_MUL; oper2_sel = 1'b1; MBR = 8'hFF; IBR = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        break;
      end
      if (k == 2 || k == 5) begin
        start = 1'b1; op = ALU_OP_LOAD; oper2_sel = 1'b0; IBR = 8'h11;
      end else begin
        start = 1'b0;
      end
    end
    chk("mul pulses latency", edges, 8);
    chk("mul pulses result", {HR, AR, Flags}, {8'hFE, 8'h01, 4'h9});
    start = 1'b1; op = ALU_OP_LOAD; oper2_sel = 1'b0; IBR = 8'h42;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b done", done, 1'b1);
    chk("b2b result", {HR, AR, Flags}, {8'hFE, 8'h42, 4'h1});
    chk("b2b busy", busy, 1'b0);
    @(negedge clk);
    chk("b2b no queued op", done, 1'b0);

    // reset sampled at edge 4 of a MUL
    op = ALU_OP_MUL; oper2_sel = 1'b0; IBR = 8'h02; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid-mul busy", busy, 1'b1);
    chk("mid-mul regs held", {HR, AR, Flags}, {8'hFE, 8'h42, 4'h1});
    arst = 1'b1;
    @(negedge clk);
    chk("abort regs", {HR, AR, Flags}, 20'h0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    arst = 1'b0;
    @(negedge clk);
    chk("abort no late done", done, 1'b0);
    run_op(ALU_OP_ADD, 1'b0, 8'h05, 8'h00, edges, busy0);
    chk("post-reset add latency", edges, 0);
    chk("post-reset add", {HR, AR, Flags}, {8'h00, 8'h05, 4'h0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
